// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset CPU control path.
// Holds the opcode constants, the ALUOp codes understood by the ALU
// controller, the main-FSM state enum and the datapath select encodings.
package cpu_pkg;

  // Opcode field values of the supported instructions
  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ALUOp codes; the ALU controller decodes these exact values
  localparam logic [2:0] ALU_R     = 3'd2;
  localparam logic [2:0] ALU_ADD   = 3'd3;
  localparam logic [2:0] ALU_SLTIU = 3'd4;
  localparam logic [2:0] ALU_SUB   = 3'd5;
  localparam logic [2:0] ALU_LUI   = 3'd6;
  localparam logic [2:0] ALU_ORI   = 3'd7;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // Main control FSM states, binary encoded
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_ERROR    = 4'd13
  } state_t;

  // ALUOp for the immediate-arithmetic group
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] res;
    case (op)
      OP_SLTIU: res = ALU_SLTIU;
      OP_ORI:   res = ALU_ORI;
      OP_LUI:   res = ALU_LUI;
      default:  res = ALU_ADD;
    endcase
    return res;
  endfunction

  // States that wait on the memory ready handshake
  function automatic logic is_mem_wait(input state_t st);
    return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-wait watchdog for the control FSM.
// Counts cycles spent waiting for memory and flags a timeout once the
// count reaches MEM_TIMEOUT-1.
// Ports:
//   clk_i     - system clock, rising edge
//   rst_i     - asynchronous active-low reset
//   clr_i     - clear the counter (has priority over en_i)
//   en_i      - increment the counter this cycle
//   timeout_o - counter has reached MEM_TIMEOUT-1
module mem_watchdog #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr_i) begin
      cnt_next = '0;
    end else if (en_i) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign timeout_o = (cnt_reg == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU.
// Sequences the shared ALU, the memory port and the register file through
// fetch/decode/execute/memory/write-back, with a ready handshake to memory
// guarded by a watchdog. Illegal opcodes and memory timeouts park the FSM
// in a sticky ERROR state until reset.
// Ports:
//   clk_i, rst_i           - clock, asynchronous active-low reset
//   instr_op_i             - opcode field of the instruction register
//   zero_i                 - ALU zero flag (branch decision)
//   mem_ready_i            - memory completes the current access
//   pc_write_o/ir_write_o  - PC and IR load strobes
//   mem_read_o/mem_write_o - memory requests, iord_o selects PC/ALUOut
//   reg_write_o, reg_dst_o, mem_to_reg_o - register file controls
//   alu_src_a_o, alu_src_b_o, alu_op_o   - ALU operand/operation selects
//   pc_src_o               - PC source select
//   instr_done_o           - pulse in the last cycle of an instruction
//   error_o                - sticky illegal-opcode / timeout flag
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic [2:0] alu_op_o,
  output logic       instr_done_o,
  output logic       error_o
);

  state_t state_reg;
  state_t state_next;
  logic   wd_timeout;
  logic   wd_clr;
  logic   wd_en;

  // Clearing on every state change means each memory wait state starts
  // with a fresh count, whichever state it was entered from.
  assign wd_clr = (state_next != state_reg);
  assign wd_en  = is_mem_wait(state_reg) && !mem_ready_i;

  mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .timeout_o (wd_timeout)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRC_B_RT;
    pc_src_o     = PC_SRC_ALU;
    alu_op_o     = 3'd0;
    instr_done_o = 1'b0;
    error_o      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        // PC+4 is computed while the instruction is read
        mem_read_o  = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        alu_op_o    = ALU_ADD;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_next = ST_DECODE;
        end else if (wd_timeout) begin
          state_next = ST_ERROR;
        end
      end

      ST_DECODE: begin
        // Branch target lands in ALUOut for a possible BRANCH next
        alu_src_b_o = SRC_B_IMM_SH2;
        alu_op_o    = ALU_ADD;
        case (instr_op_i)
          OP_R:                             state_next = ST_EXEC_R;
          OP_LW, OP_SW:                     state_next = ST_MEM_ADDR;
          OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI: state_next = ST_EXEC_I;
          OP_BEQ, OP_BNE:                   state_next = ST_BRANCH;
          OP_J:                             state_next = ST_JUMP;
          default:                          state_next = ST_ERROR;
        endcase
      end

      ST_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_RT;
        alu_op_o    = ALU_R;
        state_next  = ST_WB_R;
      end

      ST_WB_R: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        alu_op_o     = ALU_R;
        instr_done_o = 1'b1;
        state_next   = ST_FETCH;
      end

      ST_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = imm_alu_op(instr_op_i);
        state_next  = ST_WB_I;
      end

      ST_WB_I: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_next   = ST_FETCH;
      end

      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_ADD;
        state_next  = (instr_op_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end

      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) begin
          state_next = ST_WB_MEM;
        end else if (wd_timeout) begin
          state_next = ST_ERROR;
        end
      end

      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_next   = ST_FETCH;
        end else if (wd_timeout) begin
          state_next = ST_ERROR;
        end
      end

      ST_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
        state_next   = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = SRC_B_RT;
        alu_op_o     = ALU_SUB;
        pc_src_o     = PC_SRC_ALUOUT;
        pc_write_o   = ((instr_op_i == OP_BEQ) && zero_i) ||
                       ((instr_op_i == OP_BNE) && !zero_i);
        instr_done_o = 1'b1;
        state_next   = ST_FETCH;
      end

      ST_JUMP: begin
        pc_src_o     = PC_SRC_JUMP;
        pc_write_o   = 1'b1;
        instr_done_o = 1'b1;
        state_next   = ST_FETCH;
      end

      ST_ERROR: begin
        error_o = 1'b1;
      end

      default: begin
        state_next = ST_ERROR;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed checks of reset, error,
// timeout and asynchronous reset behaviour, then random instruction streams
// against a per-instruction reference model with a scoreboard.
module tb_multicycle_ctrl;

  localparam int T   = 4;
  localparam int NTX = 150;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_auto, man_ready, auto_ready, mon_en;
  wire        mem_ready = mem_auto ? auto_ready : man_ready;

  logic       pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o;
  logic       reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic [2:0] alu_op_o;
  logic       instr_done_o, error_o;

  wire [17:0] outs = {pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o,
                      reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o,
                      alu_src_b_o, pc_src_o, alu_op_o, instr_done_o, error_o};

  multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .instr_op_i   (op),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .pc_write_o   (pc_write_o),
    .ir_write_o   (ir_write_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .iord_o       (iord_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .pc_src_o     (pc_src_o),
    .alu_op_o     (alu_op_o),
    .instr_done_o (instr_done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected observable summary of one instruction
  typedef struct {
    int op;
    int cycles;   // FETCH first cycle to instr_done, inclusive
    int rd;       // cycles with mem_read asserted
    int wr;       // cycles with mem_write asserted
    int rw;       // cycles with reg_write asserted
    int dst;      // reg_dst during the write
    int m2r;      // mem_to_reg during the write
    int alu;      // alu_op in the first cycle that uses rs as operand A
    int pcw;      // pc_write in the final cycle
    int pcs;      // pc_src in the final cycle
  } exp_t;

  exp_t sb[$];
  int   delay_q[$];

  function automatic exp_t model(int opc, bit z, int df, int dm);
    exp_t e;
    e = '{default: 0};
    e.op = opc;
    case (opc)
      0:  begin e.cycles = 4; e.rw = 1; e.dst = 1; e.alu = 2; end
      8:  begin e.cycles = 4; e.rw = 1; e.alu = 3; end
      11: begin e.cycles = 4; e.rw = 1; e.alu = 4; end
      13: begin e.cycles = 4; e.rw = 1; e.alu = 7; end
      15: begin e.cycles = 4; e.rw = 1; e.alu = 6; end
      35: begin e.cycles = 5 + dm; e.rw = 1; e.m2r = 1; e.alu = 3; e.rd = dm + 1; end
      43: begin e.cycles = 4 + dm; e.wr = dm + 1; e.alu = 3; end
      4:  begin e.cycles = 3; e.alu = 5; e.pcs = 1; e.pcw = z ? 1 : 0; end
      5:  begin e.cycles = 3; e.alu = 5; e.pcs = 1; e.pcw = z ? 0 : 1; end
      default: begin e.cycles = 3; e.pcs = 2; e.pcw = 1; end  // j
    endcase
    e.cycles += df;
    e.rd     += df + 1;
    return e;
  endfunction

  // Memory model: each new request takes the next delay from delay_q and
  // answers ready after that many waiting cycles.
  int mm_wl   = 0;
  bit mm_busy = 0;
  always @(posedge clk) begin
    #2;
    if (!rst_n || !mem_auto) begin
      mm_busy    = 0;
      mm_wl      = 0;
      auto_ready = 1'b0;
    end else begin
      if (auto_ready) mm_busy = 0;
      if (mem_read_o || mem_write_o) begin
        if (!mm_busy) begin
          mm_busy = 1;
          mm_wl   = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        end
        auto_ready = (mm_wl == 0);
        if (mm_wl > 0) mm_wl--;
      end else begin
        auto_ready = 1'b0;
      end
    end
  end

  // Monitor: accumulates one instruction from its fetch to instr_done
  bit   in_instr = 0;
  int   m_cyc, m_rd, m_wr, m_rw, m_dst, m_m2r, m_alu, ntx = 0;
  bit   m_got_alu;
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      in_instr = 0;
    end else begin
      if (!in_instr && mem_read_o && !iord_o) begin
        in_instr = 1;
        m_cyc = 0; m_rd = 0; m_wr = 0; m_rw = 0;
        m_dst = 0; m_m2r = 0; m_alu = 0; m_got_alu = 0;
      end
      if (in_instr) begin
        m_cyc++;
        m_rd += int'(mem_read_o);
        m_wr += int'(mem_write_o);
        m_rw += int'(reg_write_o);
        if (reg_write_o) begin
          m_dst = int'(reg_dst_o);
          m_m2r = int'(mem_to_reg_o);
        end
        if (!m_got_alu && alu_src_a_o) begin
          m_got_alu = 1;
          m_alu = int'(alu_op_o);
        end
        if (instr_done_o) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got instr_done, expected no instruction pending");
          end else begin
            m_e = sb.pop_front();
            check("cycles", m_cyc, m_e.cycles);
            check("mem_read_cycles", m_rd, m_e.rd);
            check("mem_write_cycles", m_wr, m_e.wr);
            check("reg_write_cycles", m_rw, m_e.rw);
            check("reg_dst", m_dst, m_e.dst);
            check("mem_to_reg", m_m2r, m_e.m2r);
            check("alu_op", m_alu, m_e.alu);
            check("final_pc_write", pc_write_o, m_e.pcw);
            check("final_pc_src", pc_src_o, m_e.pcs);
            check("no_error", error_o, 0);
            $display("txn %0d op=%0d cycles=%0d exp_cycles=%0d pc_write=%0d",
                     ntx, m_e.op, m_cyc, m_e.cycles, pc_write_o);
          end
          ntx++;
          in_instr = 0;
        end
      end
    end
  end

  int legal_ops[10] = '{0, 2, 4, 5, 8, 11, 13, 15, 35, 43};

  initial begin
    op = 6'd0; zero = 1'b0; rst_n = 1'b0;
    mem_auto = 1'b0; man_ready = 1'b0; mon_en = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs, 0);

    // add, memory always ready
    man_ready = 1'b1; op = 6'd0; rst_n = 1'b1;
    @(negedge clk);
    check("add_fetch", {mem_read_o, iord_o, ir_write_o, pc_write_o, alu_src_b_o, alu_op_o}, {4'b1011, 2'd1, 3'd3});
    @(negedge clk);
    check("add_decode", {alu_src_a_o, alu_src_b_o, alu_op_o, mem_read_o}, {1'b0, 2'd3, 3'd3, 1'b0});
    @(negedge clk);
    check("add_exec", {alu_src_a_o, alu_src_b_o, alu_op_o}, {1'b1, 2'd0, 3'd2});
    @(negedge clk);
    check("add_wb", {reg_write_o, reg_dst_o, mem_to_reg_o, instr_done_o}, 4'b1101);
    @(negedge clk);
    check("add_next_fetch", {mem_read_o, instr_done_o}, 2'b10);

    // illegal opcode
    rst_n = 1'b0;
    @(negedge clk);
    op = 6'd63; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("illegal_error", outs, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("error_hold", outs, 1);
      op = 6'($urandom_range(0, 63));
    end
    rst_n = 1'b0;
    #1;
    check("error_cleared", outs, 0);

    // watchdog: no ready in FETCH
    @(negedge clk);
    man_ready = 1'b0; op = 6'd0; rst_n = 1'b1;
    for (int i = 0; i < T; i++) begin
      @(negedge clk);
      check("timeout_wait", {mem_read_o, iord_o, error_o}, 3'b100);
    end
    @(negedge clk);
    check("timeout_error", outs, 1);

    // ready arriving in the last waiting cycle wins
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (T) @(negedge clk);
    man_ready = 1'b1;
    #1;
    check("late_ready_ir_write", ir_write_o, 1);
    @(negedge clk);
    check("late_ready_decode", {error_o, alu_src_b_o, mem_read_o}, {1'b0, 2'd3, 1'b0});

    // asynchronous reset in the middle of a store
    rst_n = 1'b0;
    @(negedge clk);
    op = 6'd43; man_ready = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    man_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("sw_mem_wr", {mem_write_o, iord_o, mem_read_o}, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", outs, 0);
    @(negedge clk);
    man_ready = 1'b1; rst_n = 1'b1;
    #1;
    check("restart_idle", outs, 0);
    @(negedge clk);
    check("restart_fetch", {mem_read_o, iord_o}, 2'b10);

    // random instruction stream
    rst_n = 1'b0;
    @(negedge clk);
    mem_auto = 1'b1; mon_en = 1'b1; rst_n = 1'b1;
    for (int n = 0; n < NTX; n++) begin
      int opc, df, dm, k;
      bit z;
      opc = legal_ops[$urandom_range(0, 9)];
      z   = 1'($urandom_range(0, 1));
      df  = $urandom_range(0, T - 1);
      dm  = $urandom_range(0, T - 1);
      delay_q.push_back(df);
      if (opc == 35 || opc == 43) delay_q.push_back(dm);
      sb.push_back(model(opc, z, df, dm));
      @(posedge clk);
      #1;
      op = 6'(opc); zero = z;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!instr_done_o && k < 40);
      if (!instr_done_o) begin
        checks++;
        errors++;
        $display("FAIL instr_done_timeout: got no instr_done in %0d cycles, expected one (op=%0d)", k, opc);
        break;
      end
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
